// File: rtl/regfile_rename.sv
// Integer register file with per-register rename state (busy bit + producer tag).
// Reads are combinational with a same-cycle commit bypass; busy_cnt tracks the busy population.
module regfile_rename #(
    parameter int unsigned XLEN = 32,
    parameter int unsigned NREG = 32,
    parameter int unsigned AW   = 5,
    parameter int unsigned TAGW = 4,
    parameter int unsigned NRD  = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 wb_en,
    input  logic [AW-1:0]        wb_addr,
    input  logic [XLEN-1:0]      wb_data,
    input  logic [TAGW-1:0]      wb_tag,
    input  logic                 iss_en,
    input  logic [AW-1:0]        iss_addr,
    input  logic [TAGW-1:0]      iss_tag,
    input  logic                 flush,
    input  logic [NRD-1:0]       rd_en,
    input  logic [NRD*AW-1:0]    rd_addr,
    output logic [NRD*XLEN-1:0]  rd_data,
    output logic [NRD-1:0]       rd_busy,
    output logic [NRD*TAGW-1:0]  rd_tag,
    output logic [AW:0]          busy_cnt
);

    localparam int unsigned CW = AW + 1;

    logic [NREG-1:0][XLEN-1:0] regs_q;
    logic [NREG-1:0]           busy_q;
    logic [NREG-1:0]           busy_nxt;
    logic [NREG-1:0][TAGW-1:0] tag_q;
    logic [NREG-1:0][TAGW-1:0] tag_nxt;
    logic [CW-1:0]             cnt_nxt;
    logic [AW-1:0]             ra [NRD];
    logic                      wb_hit;
    logic                      iss_hit;

    assign wb_hit  = wb_en  && (wb_addr  != '0);
    assign iss_hit = iss_en && (iss_addr != '0);

    for (genvar p = 0; p < NRD; p++) begin : g_ra
        assign ra[p] = rd_addr[p*AW +: AW];
    end

    // Rename state update: later statements win, giving flush > rename > commit-clear
    always_comb begin
        busy_nxt = busy_q;
        tag_nxt  = tag_q;
        if (wb_hit && busy_q[wb_addr] && (tag_q[wb_addr] == wb_tag)) begin
            busy_nxt[wb_addr] = 1'b0;
            tag_nxt[wb_addr]  = '0;
        end
        if (iss_hit) begin
            busy_nxt[iss_addr] = 1'b1;
            tag_nxt[iss_addr]  = iss_tag;
        end
        if (flush) begin
            busy_nxt = '0;
            tag_nxt  = '0;
        end
    end

    always_comb begin
        cnt_nxt = '0;
        for (int i = 0; i < NREG; i++) begin
            cnt_nxt = cnt_nxt + CW'(busy_nxt[i]);
        end
    end

    // Register 0 is never written so it stays at its reset value of zero
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            regs_q <= '0;
        end else if (wb_hit) begin
            regs_q[wb_addr] <= wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q   <= '0;
            tag_q    <= '0;
            busy_cnt <= '0;
        end else begin
            busy_q   <= busy_nxt;
            tag_q    <= tag_nxt;
            busy_cnt <= cnt_nxt;
        end
    end

    // Read ports; a commit that retires the current producer is forwarded directly
    always_comb begin
        rd_data = '0;
        rd_busy = '0;
        rd_tag  = '0;
        for (int p = 0; p < NRD; p++) begin
            if (rst_n && rd_en[p] && (ra[p] != '0)) begin
                if (wb_en && (wb_addr == ra[p]) &&
                    (!busy_q[ra[p]] || (tag_q[ra[p]] == wb_tag))) begin
                    rd_data[p*XLEN +: XLEN] = wb_data;
                end else begin
                    rd_data[p*XLEN +: XLEN] = regs_q[ra[p]];
                    rd_busy[p]              = busy_q[ra[p]];
                    rd_tag[p*TAGW +: TAGW]  = busy_q[ra[p]] ? tag_q[ra[p]] : '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_regfile_rename.sv
// Bench for regfile_rename: directed scenarios with literal expectations, then
// randomized traffic checked every cycle against an array-based reference model.
module tb_regfile_rename;

    logic        clk;
    logic        rst_n;
    logic        wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
    logic [3:0]  wb_tag;
    logic        iss_en;
    logic [4:0]  iss_addr;
    logic [3:0]  iss_tag;
    logic        flush;
    logic [1:0]  rd_en;
    logic [9:0]  rd_addr;
    logic [63:0] rd_data;
    logic [1:0]  rd_busy;
    logic [7:0]  rd_tag;
    logic [5:0]  busy_cnt;

    int checks = 0;
    int errors = 0;

    logic [31:0] mreg  [32];
    logic        mbusy [32];
    logic [3:0]  mtag  [32];

    regfile_rename #(.XLEN(32), .NREG(32), .AW(5), .TAGW(4), .NRD(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data), .wb_tag(wb_tag),
        .iss_en(iss_en), .iss_addr(iss_addr), .iss_tag(iss_tag),
        .flush(flush),
        .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_busy(rd_busy), .rd_tag(rd_tag),
        .busy_cnt(busy_cnt)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_clear();
        for (int i = 0; i < 32; i++) begin
            mreg[i]  = '0;
            mbusy[i] = 1'b0;
            mtag[i]  = '0;
        end
    endtask

    function automatic int model_pop();
        int n = 0;
        for (int i = 0; i < 32; i++) n += int'(mbusy[i]);
        return n;
    endfunction

    task automatic exp_read(input logic [4:0] a, input logic en,
                            output logic [31:0] d, output logic b, output logic [3:0] t);
        d = '0; b = 1'b0; t = '0;
        if (!rst_n || !en || a == 5'd0) return;
        if (wb_en && wb_addr == a && (!mbusy[a] || mtag[a] == wb_tag)) begin
            d = wb_data;
        end else begin
            d = mreg[a];
            b = mbusy[a];
            t = mbusy[a] ? mtag[a] : 4'd0;
        end
    endtask

    // Compare all outputs with the model for the currently applied inputs
    task automatic compare();
        logic [31:0] d;
        logic        b;
        logic [3:0]  t;
        for (int p = 0; p < 2; p++) begin
            exp_read(rd_addr[p*5 +: 5], rd_en[p], d, b, t);
            chk($sformatf("rd_data%0d", p), 64'(rd_data[p*32 +: 32]), 64'(d));
            chk($sformatf("rd_busy%0d", p), 64'(rd_busy[p]), 64'(b));
            chk($sformatf("rd_tag%0d", p), 64'(rd_tag[p*4 +: 4]), 64'(t));
        end
        chk("busy_cnt", 64'(busy_cnt), 64'(model_pop()));
    endtask

    // Architectural effect of one clock edge with the current inputs
    task automatic model_update();
        logic cc;
        if (!rst_n) begin
            model_clear();
            return;
        end
        cc = 1'b0;
        if (wb_en && wb_addr != 5'd0) begin
            cc = mbusy[wb_addr] && (mtag[wb_addr] == wb_tag);
            mreg[wb_addr] = wb_data;
        end
        if (cc) mbusy[wb_addr] = 1'b0;
        if (iss_en && iss_addr != 5'd0) begin
            mbusy[iss_addr] = 1'b1;
            mtag[iss_addr]  = iss_tag;
        end
        if (flush) begin
            for (int i = 0; i < 32; i++) mbusy[i] = 1'b0;
        end
    endtask

    task automatic idle();
        wb_en = 1'b0; wb_addr = '0; wb_data = '0; wb_tag = '0;
        iss_en = 1'b0; iss_addr = '0; iss_tag = '0;
        flush = 1'b0; rd_en = '0; rd_addr = '0;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic tick();
        compare();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_rd(input logic [1:0] en, input logic [4:0] a0, input logic [4:0] a1);
        rd_en = en;
        rd_addr = {a1, a0};
    endtask

    task automatic commit(input logic [4:0] a, input logic [3:0] t, input logic [31:0] d);
        wb_en = 1'b1; wb_addr = a; wb_tag = t; wb_data = d;
    endtask

    task automatic issue(input logic [4:0] a, input logic [3:0] t);
        iss_en = 1'b1; iss_addr = a; iss_tag = t;
    endtask

    initial begin
        rst_n = 1'b0;
        idle();
        model_clear();
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Commit and read back on both ports; x0 ignores writes
        idle(); commit(5'd3, 4'd0, 32'hDEADBEEF); settle(); tick();
        idle(); set_rd(2'b11, 5'd3, 5'd3); settle();
        chk("wr_rd_p0", 64'(rd_data[31:0]), 64'hDEADBEEF);
        chk("wr_rd_p1", 64'(rd_data[63:32]), 64'hDEADBEEF);
        chk("wr_rd_busy", 64'(rd_busy), 64'd0);
        tick();
        idle(); commit(5'd0, 4'd0, 32'h1234); settle(); tick();
        idle(); set_rd(2'b01, 5'd0, 5'd0); settle();
        chk("x0_zero", 64'(rd_data[31:0]), 64'd0);
        tick();

        // Rename then matching commit with same-cycle bypass
        idle(); issue(5'd7, 4'd4); settle(); tick();
        idle(); set_rd(2'b01, 5'd7, 5'd0); settle();
        chk("ren_busy", 64'(rd_busy[0]), 64'd1);
        chk("ren_tag", 64'(rd_tag[3:0]), 64'd4);
        chk("ren_cnt", 64'(busy_cnt), 64'd1);
        tick();
        idle(); commit(5'd7, 4'd4, 32'h55); set_rd(2'b01, 5'd7, 5'd0); settle();
        chk("byp_data", 64'(rd_data[31:0]), 64'h55);
        chk("byp_busy", 64'(rd_busy[0]), 64'd0);
        tick();
        idle(); settle();
        chk("cmt_cnt", 64'(busy_cnt), 64'd0);
        tick();

        // Stale commit leaves the younger rename in place
        idle(); issue(5'd7, 4'd4); settle(); tick();
        idle(); issue(5'd7, 4'd9); settle(); tick();
        idle(); commit(5'd7, 4'd4, 32'h11); settle(); tick();
        idle(); set_rd(2'b10, 5'd0, 5'd7); settle();
        chk("stale_data", 64'(rd_data[63:32]), 64'h11);
        chk("stale_busy", 64'(rd_busy[1]), 64'd1);
        chk("stale_tag", 64'(rd_tag[7:4]), 64'd9);
        tick();
        idle(); flush = 1'b1; settle(); tick();

        // Same-edge rename and commit of one register; flush beats rename
        idle(); issue(5'd2, 4'd3); commit(5'd2, 4'd3, 32'hA5A5); settle(); tick();
        idle(); set_rd(2'b01, 5'd2, 5'd0); settle();
        chk("col_busy", 64'(rd_busy[0]), 64'd1);
        chk("col_tag", 64'(rd_tag[3:0]), 64'd3);
        chk("col_data", 64'(rd_data[31:0]), 64'hA5A5);
        tick();
        idle(); flush = 1'b1; issue(5'd4, 4'd5); settle(); tick();
        idle(); set_rd(2'b01, 5'd4, 5'd0); settle();
        chk("fl_iss_busy", 64'(rd_busy[0]), 64'd0);
        chk("fl_iss_cnt", 64'(busy_cnt), 64'd0);
        tick();

        // Flush of several renames keeps committed data
        for (int i = 0; i < 5; i++) begin
            idle(); issue(5'(i * 7 + 1), 4'(i + 1)); settle(); tick();
        end
        idle(); settle();
        chk("five_cnt", 64'(busy_cnt), 64'd5);
        tick();
        idle(); flush = 1'b1; settle(); tick();
        idle(); set_rd(2'b11, 5'd8, 5'd3); settle();
        chk("fl_cnt", 64'(busy_cnt), 64'd0);
        chk("fl_busy", 64'(rd_busy), 64'd0);
        chk("fl_keep", 64'(rd_data[63:32]), 64'hDEADBEEF);
        tick();

        // Asynchronous reset mid-run with busy registers
        idle(); issue(5'd5, 4'd2); settle(); tick();
        idle(); issue(5'd9, 4'd6); settle(); tick();
        idle(); set_rd(2'b11, 5'd5, 5'd3);
        rst_n = 1'b0;
        model_clear();
        #1;
        chk("rst_data", rd_data, 64'd0);
        chk("rst_busy", 64'(rd_busy), 64'd0);
        chk("rst_tag", 64'(rd_tag), 64'd0);
        chk("rst_cnt", 64'(busy_cnt), 64'd0);
        tick();
        rst_n = 1'b1;
        idle(); set_rd(2'b01, 5'd5, 5'd0); settle();
        chk("post_rst_x5", 64'(rd_data[31:0]), 64'd0);
        tick();

        // Randomized traffic, addresses biased toward a small set to force collisions
        for (int n = 0; n < 3000; n++) begin
            logic [4:0] a;
            idle();
            if ($urandom_range(0, 1) == 1) begin
                a = ($urandom_range(0, 3) == 0) ? 5'($urandom_range(0, 31)) : 5'($urandom_range(0, 7));
                commit(a, ($urandom_range(0, 1) == 1) ? mtag[a] : 4'($urandom_range(0, 15)), $urandom);
            end
            if ($urandom_range(0, 1) == 1) issue(5'($urandom_range(0, 7)), 4'($urandom_range(0, 15)));
            flush = ($urandom_range(0, 31) == 0);
            set_rd(2'($urandom_range(0, 3)), 5'($urandom_range(0, 8)), 5'($urandom_range(0, 8)));
            settle();
            tick();
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
